seq_detect_scheduler: RTL

Shared non-overlapping pattern detector, time-multiplexed between NREQ serial bit sources. A round-robin arbiter grants one requester at a time a frame of FRAME_LEN bits. The block counts non-overlapping occurrences of a programmable PAT_W-bit pattern in that frame and reports the count with a done pulse. It sits between the serial input channels and the status/interrupt logic.

---
 rtl/seq_detect_scheduler.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/seq_detect_scheduler.sv
// Round-robin shared non-overlapping pattern detector for NREQ serial lanes.
// Optional idle-timeout abort in RUN is enabled by defining SEQ_TIMEOUT_EN.
module seq_detect_scheduler #(
    parameter int unsigned      NREQ      = 4,
    parameter int unsigned      PAT_W     = 4,
    parameter logic [PAT_W-1:0] PAT_RST   = 4'b1101,
    parameter int unsigned      FRAME_LEN = 16,
    parameter int unsigned      CNT_W     = 5,
    parameter int unsigned      TIMEOUT   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [PAT_W-1:0]        cfg_pattern,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         bit_in,
    input  logic [NREQ-1:0]         bit_valid,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic [CNT_W-1:0]        match_count,
    output logic                    abort
);

    localparam int unsigned IdW   = $clog2(NREQ);
    localparam int unsigned FillW = $clog2(PAT_W + 1);
    localparam int unsigned BcntW = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {StIdle, StRun, StReport} state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic [PAT_W-1:0]   window_q, window_d;
    logic [FillW-1:0]   fill_q, fill_d;
    logic [BcntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   cur_cnt_q, cur_cnt_d;
    logic [CNT_W-1:0]   match_count_q, match_count_d;
    logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]     gid_q, gid_d;
    logic [IdW-1:0]     done_id_q, done_id_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;

    logic [IdW-1:0]     pick;
    logic [IdW-1:0]     next_gid;
    logic [PAT_W-1:0]   win_next;
    logic               abort_now;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
`endif

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        logic           found;
        logic [IdW-1:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IdW'((32'(rr_ptr_q) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign next_gid = (gid_q == IdW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
    assign win_next = {window_q[PAT_W-2:0], bit_in[gid_q]};

`ifdef SEQ_TIMEOUT_EN
    assign abort_now = !req[gid_q] ||
                       (!bit_valid[gid_q] && idle_cnt_q == IdleW'(TIMEOUT - 1));
`else
    assign abort_now = !req[gid_q];
`endif

    always_comb begin
        state_d       = state_q;
        pattern_d     = pattern_q;
        window_d      = window_q;
        fill_d        = fill_q;
        bit_cnt_d     = bit_cnt_q;
        cur_cnt_d     = cur_cnt_q;
        match_count_d = match_count_q;
        rr_ptr_d      = rr_ptr_q;
        gid_d         = gid_q;
        done_id_d     = done_id_q;
        done_d        = 1'b0;
        abort_d       = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        idle_cnt_d    = idle_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (cfg_we) pattern_d = cfg_pattern;
                window_d  = '0;
                fill_d    = '0;
                bit_cnt_d = '0;
                cur_cnt_d = '0;
`ifdef SEQ_TIMEOUT_EN
                idle_cnt_d = '0;
`endif
                if (|req) begin
                    gid_d   = pick;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort_now) begin
                    abort_d   = 1'b1;
                    done_id_d = gid_q;
                    rr_ptr_d  = next_gid;
                    state_d   = StIdle;
                end else if (bit_valid[gid_q]) begin
                    window_d  = win_next;
                    bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef SEQ_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                    // Window is full once this bit lands; a hit restarts the fill.
                    if (fill_q >= FillW'(PAT_W - 1) && win_next == pattern_q) begin
                        fill_d = '0;
                        if (cur_cnt_q != '1) cur_cnt_d = cur_cnt_q + 1'b1;
                    end else if (fill_q != FillW'(PAT_W)) begin
                        fill_d = fill_q + 1'b1;
                    end
                    if (bit_cnt_q == BcntW'(FRAME_LEN - 1)) begin
                        state_d       = StReport;
                        done_d        = 1'b1;
                        done_id_d     = gid_q;
                        match_count_d = cur_cnt_d;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
`endif
            end
            StReport: begin
                rr_ptr_d = next_gid;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            pattern_q     <= PAT_RST;
            window_q      <= '0;
            fill_q        <= '0;
            bit_cnt_q     <= '0;
            cur_cnt_q     <= '0;
            match_count_q <= '0;
            rr_ptr_q      <= '0;
            gid_q         <= '0;
            done_id_q     <= '0;
            done_q        <= 1'b0;
            abort_q       <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            idle_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pattern_q     <= pattern_d;
            window_q      <= window_d;
            fill_q        <= fill_d;
            bit_cnt_q     <= bit_cnt_d;
            cur_cnt_q     <= cur_cnt_d;
            match_count_q <= match_count_d;
            rr_ptr_q      <= rr_ptr_d;
            gid_q         <= gid_d;
            done_id_q     <= done_id_d;
            done_q        <= done_d;
            abort_q       <= abort_d;
`ifdef SEQ_TIMEOUT_EN
            idle_cnt_q    <= idle_cnt_d;
`endif
        end
    end

    always_comb begin
        grant = '0;
        if (state_q == StRun) grant[gid_q] = 1'b1;
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign abort       = abort_q;
    assign done_id     = done_id_q;
    assign match_count = match_count_q;

endmodule
